// File: rtl/eth_pkg.sv
// Shared constants for the Ethernet frame transmitter: FSM encodings,
// preamble/SFD bytes and the reflected CRC-32 parameters.
package eth_pkg;

  typedef logic [3:0] state_t;

  localparam state_t IDLE     = 4'd0;
  localparam state_t PREAMBLE = 4'd1;
  localparam state_t SFD      = 4'd2;
  localparam state_t MAC_DEST = 4'd3;
  localparam state_t MAC_SRC  = 4'd4;
  localparam state_t TYPE     = 4'd5;
  localparam state_t PAYLOAD  = 4'd6;
  localparam state_t PAD      = 4'd7;
  localparam state_t FCS      = 4'd8;
  localparam state_t IFG      = 4'd9;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_XOROUT    = 32'hFFFFFFFF;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int unsigned i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide reflected CRC-32 accumulator; crc is the final-XORed FCS value.
import eth_pkg::*;

module eth_crc32 (
  input  logic        clock,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_q;

  always_ff @(posedge clock) begin
    if (reset || init)
      crc_q <= CRC_INIT;
    else if (en)
      crc_q <= crc32_byte(crc_q, data);
  end

  assign crc = crc_q ^ CRC_XOROUT;

endmodule

// File: rtl/eth_frame_tx.sv
// Ethernet frame serializer: preamble, SFD, header, payload, zero pad, IFG.
// Define ETH_FRAME_TX_FCS_EN to append the CRC-32 FCS after the payload/pad.
import eth_pkg::*;

module eth_frame_tx #(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned MIN_PAYLOAD  = 46,
  parameter int unsigned MAX_PAYLOAD  = 1500,
  parameter int unsigned IFG_BYTES    = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [47:0] mac_dest,
  input  logic [47:0] mac_src,
  input  logic [15:0] eth_type,
  input  logic [10:0] payload_len,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_sof,
  output logic        tx_eof,
  output logic        busy,
  output logic        frame_done,
  output logic        len_err
);

  localparam logic [10:0] LAST_PRE = 11'(PREAMBLE_LEN - 1);
  localparam logic [10:0] LAST_IFG = 11'(IFG_BYTES - 1);
  localparam logic [10:0] MIN_LEN  = 11'(MIN_PAYLOAD);
  localparam logic [10:0] MAX_LEN  = 11'(MAX_PAYLOAD);

`ifdef ETH_FRAME_TX_FCS_EN
  localparam state_t DATA_DONE = FCS;
`else
  localparam state_t DATA_DONE = IFG;
`endif

  state_t       state, state_nxt;
  logic [10:0]  cnt;
  logic         step;
  logic [10:0]  len_q;
  logic [111:0] hdr_q;
  logic         fire;
  logic         needs_pad;
  logic [10:0]  pad_last;

  assign fire      = tx_valid && tx_ready;
  assign needs_pad = len_q < MIN_LEN;
  assign pad_last  = MIN_LEN - len_q - 11'd1;

  always_comb begin
    state_nxt = state;
    step      = 1'b0;
    case (state)
      IDLE:     if (start && payload_len <= MAX_LEN) state_nxt = PREAMBLE;
      PREAMBLE: if (fire) begin
                  if (cnt == LAST_PRE) state_nxt = SFD;
                  else step = 1'b1;
                end
      SFD:      if (fire) state_nxt = MAC_DEST;
      MAC_DEST: if (fire) begin
                  if (cnt == 11'd5) state_nxt = MAC_SRC;
                  else step = 1'b1;
                end
      MAC_SRC:  if (fire) begin
                  if (cnt == 11'd5) state_nxt = TYPE;
                  else step = 1'b1;
                end
      TYPE:     if (fire) begin
                  if (cnt == 11'd1)
                    state_nxt = (len_q != 11'd0) ? PAYLOAD : (needs_pad ? PAD : DATA_DONE);
                  else step = 1'b1;
                end
      PAYLOAD:  if (fire) begin
                  if (cnt == len_q - 11'd1) state_nxt = needs_pad ? PAD : DATA_DONE;
                  else step = 1'b1;
                end
      PAD:      if (fire) begin
                  if (cnt == pad_last) state_nxt = DATA_DONE;
                  else step = 1'b1;
                end
`ifdef ETH_FRAME_TX_FCS_EN
      FCS:      if (fire) begin
                  if (cnt == 11'd3) state_nxt = IFG;
                  else step = 1'b1;
                end
`endif
      IFG:      if (cnt == LAST_IFG) state_nxt = IDLE;
                else step = 1'b1;
      default:  state_nxt = IDLE;
    endcase
  end

  // Counter restarts on every state change so each field counts from zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      len_q   <= '0;
      hdr_q   <= '0;
      len_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= (state_nxt != state) ? '0 : (step ? cnt + 11'd1 : cnt);
      len_err <= (state == IDLE) && start && (payload_len > MAX_LEN);
      if (state == IDLE && state_nxt == PREAMBLE) begin
        hdr_q <= {mac_dest, mac_src, eth_type};
        len_q <= payload_len;
      end else if (fire && (state == MAC_DEST || state == MAC_SRC || state == TYPE)) begin
        hdr_q <= {hdr_q[103:0], 8'h00};
      end
    end
  end

`ifdef ETH_FRAME_TX_FCS_EN
  logic [31:0] fcs;
  logic [7:0]  fcs_byte;

  eth_crc32 u_crc32 (
    .clock (clock),
    .reset (reset),
    .init  (state == IDLE),
    .en    (fire && state >= MAC_DEST && state <= PAD),
    .data  (tx_data),
    .crc   (fcs)
  );

  always_comb begin
    case (cnt[1:0])
      2'd0:    fcs_byte = fcs[7:0];
      2'd1:    fcs_byte = fcs[15:8];
      2'd2:    fcs_byte = fcs[23:16];
      default: fcs_byte = fcs[31:24];
    endcase
  end
`endif

  always_comb begin
    tx_data  = '0;
    tx_valid = 1'b0;
    case (state)
      PREAMBLE: begin tx_data = PREAMBLE_BYTE;   tx_valid = 1'b1; end
      SFD:      begin tx_data = SFD_BYTE;        tx_valid = 1'b1; end
      MAC_DEST,
      MAC_SRC,
      TYPE:     begin tx_data = hdr_q[111:104];  tx_valid = 1'b1; end
      PAYLOAD:  begin tx_data = pl_data;         tx_valid = pl_valid; end
      PAD:      begin tx_data = '0;              tx_valid = 1'b1; end
`ifdef ETH_FRAME_TX_FCS_EN
      FCS:      begin tx_data = fcs_byte;        tx_valid = 1'b1; end
`endif
      default:  begin tx_data = '0;              tx_valid = 1'b0; end
    endcase
  end

  assign pl_ready   = (state == PAYLOAD) && tx_ready;
  assign tx_sof     = (state == PREAMBLE) && (cnt == 11'd0);
  assign busy       = (state != IDLE);
  assign frame_done = (state == IFG) && (cnt == LAST_IFG);

`ifdef ETH_FRAME_TX_FCS_EN
  assign tx_eof = (state == FCS) && (cnt == 11'd3);
`else
  assign tx_eof = ((state == PAYLOAD) && tx_valid && (cnt == len_q - 11'd1) && !needs_pad) ||
                  ((state == PAD) && (cnt == pad_last));
`endif

endmodule

// File: tb/tb_eth_frame_tx.sv
// Scoreboard bench for eth_frame_tx; FCS checks follow ETH_FRAME_TX_FCS_EN.
`timescale 1ns/1ps
module tb_eth_frame_tx;

  localparam int IFG  = 12;
  localparam int MINP = 46;

  logic        clock = 1'b0;
  logic        reset, start;
  logic [47:0] mac_dest, mac_src;
  logic [15:0] eth_type;
  logic [10:0] payload_len;
  logic [7:0]  pl_data;
  logic        pl_valid, pl_ready;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, tx_sof, tx_eof;
  logic        busy, frame_done, len_err;
  logic        crc_init, crc_en;
  logic [7:0]  crc_data;
  logic [31:0] crc_out;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eof;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] obs_q[$];
  logic [7:0] pay [0:1499];

  always #5 clock = ~clock;

  eth_frame_tx #(
    .PREAMBLE_LEN (7),
    .MIN_PAYLOAD  (46),
    .MAX_PAYLOAD  (1500),
    .IFG_BYTES    (12)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .mac_dest    (mac_dest),
    .mac_src     (mac_src),
    .eth_type    (eth_type),
    .payload_len (payload_len),
    .pl_data     (pl_data),
    .pl_valid    (pl_valid),
    .pl_ready    (pl_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_sof      (tx_sof),
    .tx_eof      (tx_eof),
    .busy        (busy),
    .frame_done  (frame_done),
    .len_err     (len_err)
  );

  eth_crc32 u_crc (
    .clock (clock),
    .reset (reset),
    .init  (crc_init),
    .en    (crc_en),
    .data  (crc_data),
    .crc   (crc_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'd0, b};
    for (int k = 0; k < 8; k++)
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  function automatic logic [10:0] outs_vec();
    return {tx_valid, tx_sof, tx_eof, pl_ready, busy, frame_done, len_err, 4'b0} | {3'b0, tx_data};
  endfunction

  task automatic push_frame(input int len);
    logic [7:0] body[$];
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 7; i++) exp_q.push_back('{8'h55, (i == 0), 1'b0});
    exp_q.push_back('{8'hD5, 1'b0, 1'b0});
    for (int i = 0; i < 6; i++) body.push_back(8'(mac_dest >> (40 - 8 * i)));
    for (int i = 0; i < 6; i++) body.push_back(8'(mac_src >> (40 - 8 * i)));
    body.push_back(eth_type[15:8]);
    body.push_back(eth_type[7:0]);
    for (int i = 0; i < len; i++) body.push_back(pay[i]);
    for (int i = len; i < MINP; i++) body.push_back(8'h00);
    foreach (body[i]) begin
      exp_q.push_back('{body[i], 1'b0, 1'b0});
      c = crc_step(c, body[i]);
    end
`ifdef ETH_FRAME_TX_FCS_EN
    c = ~c;
    for (int i = 0; i < 4; i++) exp_q.push_back('{8'(c >> (8 * i)), 1'b0, 1'b0});
`endif
    exp_q[exp_q.size() - 1].eof = 1'b1;
  endtask

  task automatic run_frame(input int len, input bit stall, input bit gaps,
                           input bit hold_start, input int abort_at);
    int    pidx, eof_cyc, done_cyc;
    bit    presented, prev_stall, done;
    beat_t e, prev;
    logic [31:0] c;
    pidx = 0; eof_cyc = 0; done_cyc = 0;
    presented = 0; prev_stall = 0; done = 0; prev = '0;
    payload_len = 11'(len);
    exp_q.delete();
    obs_q.delete();
    push_frame(len);
    for (int k = 0; k < 8000 && !done; k++) begin
      @(posedge clock); #1;
      start    = (k == 0) || hold_start;
      tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (gaps && !presented && $urandom_range(0, 3) == 0) pl_valid = 1'b0;
      else pl_valid = (pidx < len);
      pl_data = (pidx < len) ? pay[pidx] : 8'h00;
      @(negedge clock);
      if (prev_stall)
        check("stall_hold", 64'({tx_valid, tx_data, tx_sof, tx_eof}),
              64'({1'b1, prev.data, prev.sof, prev.eof}));
      prev_stall = tx_valid && !tx_ready;
      prev = '{tx_data, tx_sof, tx_eof};
      if (tx_valid && tx_ready) begin
        obs_q.push_back(tx_data);
        check("byte_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("byte", 64'({tx_data, tx_sof, tx_eof}), 64'({e.data, e.sof, e.eof}));
        end
        if (tx_eof) eof_cyc = k;
      end
      if (pl_valid && pl_ready) pidx++;
      presented = pl_valid && !pl_ready;
      if (frame_done) begin
        done_cyc = k;
        done = 1;
      end
      if (abort_at >= 0 && pidx == abort_at) break;
    end
    if (abort_at < 0) begin
      check("frame_done_seen", 64'(done), 64'(1));
      check("queue_empty", 64'(exp_q.size()), 64'(0));
      check("eof_to_done", 64'(done_cyc - eof_cyc), 64'(IFG));
      @(posedge clock); #1;
      start = 1'b0;
      pl_valid = 1'b0;
      @(negedge clock);
      check("idle_after", 64'({busy, frame_done, tx_valid}), 64'(0));
`ifdef ETH_FRAME_TX_FCS_EN
      c = 32'hFFFFFFFF;
      for (int i = 8; i < obs_q.size(); i++) c = crc_step(c, obs_q[i]);
      check("fcs_residue", 64'(c), 64'(32'hDEBB20E3));
`endif
    end
  endtask

  initial begin
    int n_err, n_busy, n_done, n_eof;
    string s;
    reset = 1'b1; start = 1'b0; tx_ready = 1'b0; pl_valid = 1'b0; pl_data = '0;
    mac_dest = 48'h0123_4567_89AB; mac_src = 48'hA1B2_C3D4_E5F6;
    eth_type = 16'h0800; payload_len = '0;
    crc_init = 1'b0; crc_en = 1'b0; crc_data = '0;
    for (int i = 0; i < 1500; i++) pay[i] = 8'(i * 37 + 11);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_outputs", 64'(outs_vec()), 64'(0));
    @(posedge clock); #1;
    reset = 1'b0;

    run_frame(64, 0, 0, 0, -1);
    run_frame(64, 1, 1, 0, -1);
    run_frame(10, 0, 0, 0, -1);
    run_frame(0, 0, 1, 0, -1);
    run_frame(46, 1, 0, 1, -1);
    run_frame(1500, 1, 1, 0, -1);

    payload_len = 11'd1501;
    n_err = 0; n_busy = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clock); #1;
      start = (k == 0);
      @(negedge clock);
      if (len_err) n_err++;
      if (busy || tx_valid) n_busy++;
    end
    check("len_err_pulses", 64'(n_err), 64'(1));
    check("len_err_idle", 64'(n_busy), 64'(0));

    run_frame(64, 0, 0, 0, 20);
    @(posedge clock); #1;
    reset = 1'b1; start = 1'b0; pl_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("abort_outputs", 64'(outs_vec()), 64'(0));
    @(posedge clock); #1;
    reset = 1'b0;
    n_done = 0; n_eof = 0; n_busy = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (frame_done) n_done++;
      if (tx_eof) n_eof++;
      if (busy) n_busy++;
      @(posedge clock); #1;
    end
    check("abort_no_done", 64'({n_done[15:0], n_eof[15:0], n_busy[15:0]}), 64'(0));
    run_frame(64, 0, 0, 0, -1);

    s = "123456789";
    @(posedge clock); #1;
    crc_init = 1'b1;
    @(posedge clock); #1;
    crc_init = 1'b0;
    for (int i = 0; i < 9; i++) begin
      crc_en = 1'b1;
      crc_data = s[i];
      @(posedge clock); #1;
    end
    crc_en = 1'b0;
    @(negedge clock);
    check("crc_check_value", 64'(crc_out), 64'(32'hCBF43926));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/eth_frame_tx.md
ETH_FRAME_TX -- requirements
Module: eth_frame_tx

Interface
REQ-001 SHALL have parameter PREAMBLE_LEN, default 7, number of 0x55 preamble bytes before SFD.
REQ-002 SHALL have parameter MIN_PAYLOAD, default 46, minimum payload bytes; shorter payloads are zero-padded.
REQ-003 SHALL have parameter MAX_PAYLOAD, default 1500, largest accepted payload_len.
REQ-004 SHALL have parameter IFG_BYTES, default 12, idle byte-times after each frame.
REQ-005 SHALL have ports: clock input 1 (rising-edge clock); reset input 1 (synchronous, active-high).
REQ-006 SHALL have ports: start input 1 (frame request, sampled in IDLE); mac_dest input 48; mac_src input 48; eth_type input 16; payload_len input 11.
REQ-007 SHALL have ports: pl_data input 8, pl_valid input 1, pl_ready output 1 (payload byte stream).
REQ-008 SHALL have ports: tx_data output 8, tx_valid output 1, tx_ready input 1, tx_sof output 1, tx_eof output 1 (frame byte stream).
REQ-009 SHALL have ports: busy output 1, frame_done output 1, len_err output 1.

Function
REQ-010 SHALL use states IDLE, PREAMBLE, SFD, MAC_DEST, MAC_SRC, TYPE, PAYLOAD, PAD, FCS, IFG, in that order.
REQ-011 SHALL, on start=1 in IDLE with payload_len<=MAX_PAYLOAD, latch mac_dest, mac_src, eth_type and payload_len, and enter PREAMBLE next cycle.
REQ-012 SHALL, on start=1 in IDLE with payload_len>MAX_PAYLOAD, stay in IDLE and pulse len_err for exactly one cycle.
REQ-013 SHALL ignore start outside IDLE; busy=1 in every state except IDLE.
REQ-014 SHALL advance a byte only on the tx_valid&&tx_ready cycle; while tx_valid&&!tx_ready, tx_data/tx_sof/tx_eof SHALL hold stable.
REQ-015 SHALL drive tx_valid=1 in PREAMBLE, SFD, MAC_DEST, MAC_SRC, TYPE, PAD and FCS; tx_valid=0 in IDLE and IFG.
REQ-016 SHALL emit PREAMBLE_LEN bytes of 0x55, then SFD byte 0xD5; tx_sof=1 on the first preamble byte only.
REQ-017 SHALL emit mac_dest, mac_src and eth_type MSB byte first (mac_dest[47:40] first).
REQ-018 SHALL in PAYLOAD pass pl_data to tx_data, with tx_valid=pl_valid and pl_ready=tx_ready; pl_ready=0 in every other state.
REQ-019 SHALL allow payload underrun (pl_valid=0) as a tx_valid gap without a state change.
REQ-020 SHALL skip PAYLOAD when payload_len=0.
REQ-021 SHALL enter PAD after the payload when payload_len<MIN_PAYLOAD, emitting MIN_PAYLOAD-payload_len bytes of 0x00; otherwise PAD SHALL be skipped.
REQ-022 SHALL use an 11-bit byte counter per field, cleared on each state entry.
REQ-023 SHALL assert tx_eof on the last byte of the frame: last FCS byte, or the last payload/pad byte when FCS is compiled out.
REQ-024 SHALL stay IFG_BYTES cycles in IFG, then pulse frame_done for one cycle and return to IDLE.
REQ-025 SHALL accept a start on the cycle frame_done is high only after IDLE is reached, i.e. one cycle later.

Reset
REQ-026 SHALL on reset=1 force IDLE, clear all counters, and drive tx_valid, tx_sof, tx_eof, pl_ready, busy, frame_done, len_err and tx_data to 0.
REQ-027 SHALL abort any frame in progress when reset is asserted mid-frame, with no frame_done and no tx_eof.

Configuration
REQ-028 SHALL, when macro ETH_FRAME_TX_FCS_EN is defined, append a 4-byte CRC-32 FCS over MAC_DEST..PAD.
REQ-029 The FCS SHALL use polynomial 0x04C11DB7 reflected, init 0xFFFFFFFF and final XOR 0xFFFFFFFF, sent least-significant byte first.
REQ-030 SHALL, when ETH_FRAME_TX_FCS_EN is undefined, omit the FCS state and the CRC logic; the frame SHALL end after PAYLOAD/PAD.

Structure
REQ-031 SHALL take the state enum, SFD/preamble byte constants and CRC constants from shared package eth_pkg.
REQ-032 SHALL place CRC-32 byte-update logic in sub-module eth_crc32 (ports clock, reset, init, en, data[7:0], crc[31:0]), instantiated only under ETH_FRAME_TX_FCS_EN.

Verification
REQ-033 Payload_len=64 with tx_ready=1 -> 7x0x55, 0xD5, 14 header bytes, 64 payload bytes, 4 FCS bytes; frame_done 12 cycles after tx_eof.
REQ-034 Payload_len=10 -> 10 payload bytes then 36 bytes of 0x00; CRC-32 run over MAC_DEST..FCS leaves residue 0xDEBB20E3.
REQ-035 Payload_len=1501 -> len_err one-cycle pulse, busy stays 0, tx_valid stays 0.
REQ-036 tx_ready toggled randomly 50% plus pl_valid gaps -> byte sequence identical to the REQ-033 run; outputs held stable during stalls.
REQ-037 Reset asserted at payload byte 20 -> next cycle IDLE with all outputs 0; no frame_done; the following start gives a clean frame.
REQ-038 eth_crc32 unit test: ASCII "123456789" -> crc 0xCBF43926.
